// File: rtl/decode_issue.sv
// decode_issue: decodes 32-bit MIPS-style instructions into ALU controls and
// holds them in an output pipeline register. Optional RAW/WAW scoreboard is
// enabled with the DECODE_SCOREBOARD_EN macro.
module decode_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_op,
  output logic [4:0]  out_rr1,
  output logic [4:0]  out_rr2,
  output logic [4:0]  out_wr,
  output logic [4:0]  out_shift_amt,
  output logic [31:0] out_imm,
  output logic        out_use_imm,
  output logic        out_wen,
  output logic        illegal,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  output logic [15:0] stall_cnt
);

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SGT = 6'h2E;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLL = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_SRA = 4'd6;
  localparam logic [3:0] ALU_GT  = 4'd7;
  localparam logic [3:0] ALU_LT  = 4'd8;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;

  assign opcode = in_instr[31:26];
  assign rs     = in_instr[25:21];
  assign rt     = in_instr[20:16];
  assign rd     = in_instr[15:11];
  assign shamt  = in_instr[10:6];
  assign funct  = in_instr[5:0];
  assign imm16  = in_instr[15:0];

  logic        dec_legal, dec_use_imm, dec_wen, dec_rd_rs, dec_rd_rt;
  logic [3:0]  dec_op;
  logic [4:0]  dec_rr1, dec_rr2, dec_wr;
  logic [31:0] dec_imm;
  logic        hazard, accept;

  // Instruction decode; shifts read rt on both ports, I-type writes rt
  always_comb begin
    dec_legal   = 1'b0;
    dec_op      = ALU_ADD;
    dec_rr1     = rs;
    dec_rr2     = rt;
    dec_wr      = rd;
    dec_imm     = 32'd0;
    dec_use_imm = 1'b0;
    dec_rd_rs   = 1'b0;
    dec_rd_rt   = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        dec_legal = 1'b1;
        dec_rd_rs = 1'b1;
        dec_rd_rt = 1'b1;
        case (funct)
          FN_ADD: dec_op = ALU_ADD;
          FN_SUB: dec_op = ALU_SUB;
          FN_AND: dec_op = ALU_AND;
          FN_OR:  dec_op = ALU_OR;
          FN_SGT: dec_op = ALU_GT;
          FN_SLT: dec_op = ALU_LT;
          FN_SLL, FN_SRL, FN_SRA: begin
            dec_op    = (funct == FN_SLL) ? ALU_SLL :
                        (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
            dec_rr1   = rt;
            dec_rd_rs = 1'b0;
          end
          default: begin
            dec_legal = 1'b0;
            dec_rd_rs = 1'b0;
            dec_rd_rt = 1'b0;
          end
        endcase
      end
      OPC_ADDI, OPC_SLTI, OPC_ANDI, OPC_ORI: begin
        dec_legal   = 1'b1;
        dec_wr      = rt;
        dec_use_imm = 1'b1;
        dec_rd_rs   = 1'b1;
        if (opcode == OPC_ANDI || opcode == OPC_ORI) begin
          dec_imm = {16'd0, imm16};
        end else begin
          dec_imm = {{16{imm16[15]}}, imm16};
        end
        dec_op = (opcode == OPC_ADDI) ? ALU_ADD :
                 (opcode == OPC_SLTI) ? ALU_LT  :
                 (opcode == OPC_ANDI) ? ALU_AND : ALU_OR;
      end
      default: ;
    endcase
  end

  assign dec_wen = dec_legal && (dec_wr != 5'd0);

`ifdef DECODE_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Hazard check against registered busy bits only (no writeback bypass)
  assign hazard = dec_legal && ((dec_rd_rs && busy_q[rs]) ||
                                (dec_rd_rt && busy_q[rt]) ||
                                busy_q[dec_wr]);

  // Busy-bit update: writeback clears, issue sets, set wins on collision
  always_comb begin
    busy_d      = busy_q;
    stall_cnt_d = stall_cnt_q;
    if (wb_valid) busy_d[wb_addr] = 1'b0;
    if (accept && dec_wen) busy_d[dec_wr] = 1'b1;
    busy_d[0] = 1'b0;
    if (in_valid && hazard && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Scoreboard and stall counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= 32'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_sb;
  assign unused_sb = ^{wb_valid, wb_addr, dec_rd_rs, dec_rd_rt};
  assign hazard    = 1'b0;
  assign stall_cnt = 16'd0;
`endif

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  logic        out_valid_d, out_use_imm_d, out_wen_d, illegal_d;
  logic [3:0]  out_op_d;
  logic [4:0]  out_rr1_d, out_rr2_d, out_wr_d, out_shift_amt_d;
  logic [31:0] out_imm_d;
  logic        out_valid_q, out_use_imm_q, out_wen_q, illegal_q;
  logic [3:0]  out_op_q;
  logic [4:0]  out_rr1_q, out_rr2_q, out_wr_q, out_shift_amt_q;
  logic [31:0] out_imm_q;

  // Output register: load on legal accept, drop valid when consumed, hold otherwise
  always_comb begin
    out_valid_d     = out_valid_q;
    out_op_d        = out_op_q;
    out_rr1_d       = out_rr1_q;
    out_rr2_d       = out_rr2_q;
    out_wr_d        = out_wr_q;
    out_shift_amt_d = out_shift_amt_q;
    out_imm_d       = out_imm_q;
    out_use_imm_d   = out_use_imm_q;
    out_wen_d       = out_wen_q;
    illegal_d       = accept && !dec_legal;
    if (accept && dec_legal) begin
      out_valid_d     = 1'b1;
      out_op_d        = dec_op;
      out_rr1_d       = dec_rr1;
      out_rr2_d       = dec_rr2;
      out_wr_d        = dec_wr;
      out_shift_amt_d = shamt;
      out_imm_d       = dec_imm;
      out_use_imm_d   = dec_use_imm;
      out_wen_d       = dec_wen;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q     <= 1'b0;
      out_op_q        <= 4'd0;
      out_rr1_q       <= 5'd0;
      out_rr2_q       <= 5'd0;
      out_wr_q        <= 5'd0;
      out_shift_amt_q <= 5'd0;
      out_imm_q       <= 32'd0;
      out_use_imm_q   <= 1'b0;
      out_wen_q       <= 1'b0;
      illegal_q       <= 1'b0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_op_q        <= out_op_d;
      out_rr1_q       <= out_rr1_d;
      out_rr2_q       <= out_rr2_d;
      out_wr_q        <= out_wr_d;
      out_shift_amt_q <= out_shift_amt_d;
      out_imm_q       <= out_imm_d;
      out_use_imm_q   <= out_use_imm_d;
      out_wen_q       <= out_wen_d;
      illegal_q       <= illegal_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_op        = out_op_q;
  assign out_rr1       = out_rr1_q;
  assign out_rr2       = out_rr2_q;
  assign out_wr        = out_wr_q;
  assign out_shift_amt = out_shift_amt_q;
  assign out_imm       = out_imm_q;
  assign out_use_imm   = out_use_imm_q;
  assign out_wen       = out_wen_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_decode_issue.sv
// Testbench for decode_issue: directed instruction sequences checked every
// cycle against an instruction-level reference model, plus literal spot checks.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [4:0]  out_rr1, out_rr2, out_wr, out_shift_amt;
  logic [31:0] out_imm;
  logic        out_use_imm, out_wen, illegal;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [15:0] stall_cnt;

  decode_issue dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rr1(out_rr1), .out_rr2(out_rr2), .out_wr(out_wr),
    .out_shift_amt(out_shift_amt), .out_imm(out_imm),
    .out_use_imm(out_use_imm), .out_wen(out_wen), .illegal(illegal),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

`ifdef DECODE_SCOREBOARD_EN
  localparam logic SB_ON = 1'b1;
  localparam int unsigned EXP_STALL = 4;
`else
  localparam logic SB_ON = 1'b0;
  localparam int unsigned EXP_STALL = 0;
`endif

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  logic        chk_en = 1'b0;
  int unsigned cyc = 0;

  typedef struct packed {
    logic        legal;
    logic [3:0]  op;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  wr;
    logic [4:0]  sh;
    logic [31:0] imm;
    logic        use_imm;
    logic        wen;
    logic        rs_rd;
    logic        rt_rd;
  } dec_t;

  // reference model state
  logic        m_valid = 1'b0;
  dec_t        m_out = '0;
  logic [31:0] m_busy = 32'd0;
  logic [15:0] m_stall = 16'd0;
  logic        m_illegal = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Instruction semantics straight from the opcode/funct table
  function automatic dec_t decode_ref(input logic [31:0] i);
    dec_t d;
    logic [5:0] opc;
    logic [5:0] fn;
    opc = i[31:26];
    fn  = i[5:0];
    d = '0;
    d.rr1 = i[25:21];
    d.rr2 = i[20:16];
    d.sh  = i[10:6];
    if (opc == 6'h00) begin
      d.wr = i[15:11];
      d.legal = 1'b1;
      d.rs_rd = 1'b1;
      d.rt_rd = 1'b1;
      case (fn)
        6'h20: d.op = 4'd0;
        6'h22: d.op = 4'd1;
        6'h24: d.op = 4'd2;
        6'h25: d.op = 4'd3;
        6'h2E: d.op = 4'd7;
        6'h2A: d.op = 4'd8;
        6'h00: begin d.op = 4'd4; d.rr1 = i[20:16]; d.rs_rd = 1'b0; end
        6'h02: begin d.op = 4'd5; d.rr1 = i[20:16]; d.rs_rd = 1'b0; end
        6'h03: begin d.op = 4'd6; d.rr1 = i[20:16]; d.rs_rd = 1'b0; end
        default: d = '0;
      endcase
    end else begin
      d.wr = i[20:16];
      d.use_imm = 1'b1;
      d.rs_rd = 1'b1;
      d.legal = 1'b1;
      case (opc)
        6'h08: begin d.op = 4'd0; d.imm = 32'($signed(i[15:0])); end
        6'h0C: begin d.op = 4'd2; d.imm = {16'd0, i[15:0]}; end
        6'h0D: begin d.op = 4'd3; d.imm = {16'd0, i[15:0]}; end
        6'h0A: begin d.op = 4'd8; d.imm = 32'($signed(i[15:0])); end
        default: d = '0;
      endcase
    end
    d.wen = d.legal && (d.wr != 5'd0);
    if (!d.legal) begin
      d.rs_rd = 1'b0;
      d.rt_rd = 1'b0;
    end
    return d;
  endfunction

  function automatic logic hz_ref(input dec_t d);
    if (!SB_ON || !d.legal) return 1'b0;
    return (d.rs_rd && m_busy[d.rr1 == d.rr2 && !d.rs_rd ? d.rr2 : d.rr1]) ||
           (d.rt_rd && m_busy[d.rr2]) || m_busy[d.wr];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model advance on each rising edge
  always @(posedge clk) begin : model
    dec_t d;
    logic hz;
    logic acc;
    if (reset) begin
      m_valid = 1'b0;
      m_out = '0;
      m_busy = 32'd0;
      m_stall = 16'd0;
      m_illegal = 1'b0;
    end else begin
      d = decode_ref(in_instr);
      hz = hz_ref(d);
      acc = in_valid && (!m_valid || out_ready) && !hz;
      if (SB_ON && in_valid && hz && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      m_illegal = acc && !d.legal;
      if (SB_ON && wb_valid) m_busy[wb_addr] = 1'b0;
      if (SB_ON && acc && d.wen) m_busy[d.wr] = 1'b1;
      if (acc && d.legal) begin
        m_valid = 1'b1;
        m_out = d;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("illegal", 32'(illegal), 32'(m_illegal));
      chk("in_ready", 32'(in_ready),
          32'((!m_valid || out_ready) && !hz_ref(decode_ref(in_instr))));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      if (m_valid) begin
        chk("out_op", 32'(out_op), 32'(m_out.op));
        chk("out_rr1", 32'(out_rr1), 32'(m_out.rr1));
        chk("out_rr2", 32'(out_rr2), 32'(m_out.rr2));
        chk("out_wr", 32'(out_wr), 32'(m_out.wr));
        chk("out_shift_amt", 32'(out_shift_amt), 32'(m_out.sh));
        chk("out_imm", out_imm, m_out.imm);
        chk("out_use_imm", 32'(out_use_imm), 32'(m_out.use_imm));
        chk("out_wen", 32'(out_wen), 32'(m_out.wen));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and wait (bounded) until it is accepted
  task automatic send(input logic [31:0] ins);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    for (int k = 0; k < 40 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_chk++;
      $display("FAIL send_timeout: instr %08h not accepted within 40 cycles", ins);
    end
  endtask

  task automatic retire(input logic [4:0] a);
    wb_valid = 1'b1;
    wb_addr = a;
    step();
    wb_valid = 1'b0;
  endtask

  logic [31:0] seq [8];
  int unsigned c0;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = 32'd0;
    out_ready = 1'b1; wb_valid = 1'b0; wb_addr = 5'd0;
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_op", 32'(out_op), 32'd0);

    // add $3,$1,$2
    send(32'h00221820);
    @(negedge clk);
    chk("add_op", 32'(out_op), 32'd0);
    chk("add_rr1", 32'(out_rr1), 32'd1);
    chk("add_rr2", 32'(out_rr2), 32'd2);
    chk("add_wr", 32'(out_wr), 32'd3);
    chk("add_wen", 32'(out_wen), 32'd1);
    chk("add_use_imm", 32'(out_use_imm), 32'd0);
    step();
    retire(5'd3);

    // addi $4,$0,-5 and ori $5,$0,0x8000
    send(32'h2004FFFB);
    @(negedge clk);
    chk("addi_imm", out_imm, 32'hFFFFFFFB);
    chk("addi_wr", 32'(out_wr), 32'd4);
    chk("addi_use_imm", 32'(out_use_imm), 32'd1);
    step();
    send(32'h34058000);
    @(negedge clk);
    chk("ori_imm", out_imm, 32'h00008000);
    chk("ori_op", 32'(out_op), 32'd3);
    step();
    retire(5'd4);
    retire(5'd5);

    // RAW: add $3,$1,$2 then sub $6,$3,$1 held until $3 retires
    send(32'h00221820);
    in_valid = 1'b1;
    in_instr = 32'h00613022;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (SB_ON) chk("raw_hold", 32'(in_ready), 32'd0);
      step();
    end
    wb_valid = 1'b1; wb_addr = 5'd3;
    @(negedge clk);
    if (SB_ON) chk("raw_no_bypass", 32'(in_ready), 32'd0);
    step();
    wb_valid = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("raw_stall_cnt", 32'(stall_cnt), EXP_STALL);
    if (SB_ON) begin
      send(32'h00613022);
      @(negedge clk);
      chk("sub_op", 32'(out_op), 32'd1);
      chk("sub_wr", 32'(out_wr), 32'd6);
      step();
    end
    retire(5'd6);

    // backpressure: out_ready low for 3 cycles
    out_ready = 1'b0;
    send(32'h00223820);
    in_valid = 1'b1;
    in_instr = 32'h00224024;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_wr_held", 32'(out_wr), 32'd7);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_and_wr", 32'(out_wr), 32'd8);
    chk("bp_and_op", 32'(out_op), 32'd2);
    retire(5'd7);
    retire(5'd8);

    // illegal opcode 0x3F
    send(32'hFC000000);
    @(negedge clk);
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_no_valid", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    chk("ill_one_cycle", 32'(illegal), 32'd0);

    // writes to $0 never mark busy
    send(32'h00220020);
    @(negedge clk);
    chk("r0_wen", 32'(out_wen), 32'd0);
    chk("r0_wr", 32'(out_wr), 32'd0);
    send(32'h00004820);
    @(negedge clk);
    chk("r0_no_stall", 32'(stall_cnt), EXP_STALL);
    step();
    retire(5'd9);

    // back-to-back independent instructions, one per cycle
    seq[0] = 32'h00025100; // sll $10,$2,4
    seq[1] = 32'h000258C2; // srl $11,$2,3
    seq[2] = 32'h00026043; // sra $12,$2,1
    seq[3] = 32'h0022682E; // sgt $13,$1,$2
    seq[4] = 32'h0022702A; // slt $14,$1,$2
    seq[5] = 32'h302FF0F0; // andi $15,$1,0xF0F0
    seq[6] = 32'h2830FFFF; // slti $16,$1,-1
    seq[7] = 32'h00228825; // or $17,$1,$2
    c0 = cyc;
    for (int k = 0; k < 8; k++) send(seq[k]);
    chk("b2b_cycles", cyc - c0, 32'd8);
    @(negedge clk);
    chk("b2b_last_op", 32'(out_op), 32'd3);
    step();
    for (int r = 10; r < 18; r++) retire(5'(r));

    // same-cycle retire and issue of $20: set wins
    wb_valid = 1'b1; wb_addr = 5'd20;
    send(32'h0022A020);
    wb_valid = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h0281A822;
    @(negedge clk);
    if (SB_ON) chk("set_wins", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    retire(5'd20);
    send(32'h0281A822);
    step();
    retire(5'd21);

    // reset drops a held instruction
    out_ready = 1'b0;
    send(32'h0022B020);
    @(negedge clk);
    chk("mid_held", 32'(out_valid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_wr", 32'(out_wr), 32'd0);
    chk("mid_rst_stall", 32'(stall_cnt), 32'd0);
    out_ready = 1'b1;
    send(32'h0022B020);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
